// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller: one byte-wide RAM behind an arbitrated
// data port (priority) and a little-endian multi-beat instruction fetch port.
module unified_mem_ctrl #(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH       = 16,
  parameter int unsigned PROT_BASE         = 'h020,
  parameter int unsigned PROT_TOP          = 'h03F
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [MEMORY_ADDR_WIDTH-1:0] i_addr,
  output logic [INSTR_WIDTH-1:0]       i_rdata,
  output logic                         i_valid,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [MEMORY_ADDR_WIDTH-1:0] d_addr,
  input  logic [MEMORY_DATA_WIDTH-1:0] d_wdata,
  output logic [MEMORY_DATA_WIDTH-1:0] d_rdata,
  output logic                         d_valid,
  input  logic                         prot_unlock,
  input  logic                         prot_err_clr,
  output logic                         prot_err,
  output logic                         cpu_wait
);

  localparam int unsigned DW    = MEMORY_DATA_WIDTH;
  localparam int unsigned AW    = MEMORY_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned BEATS = INSTR_WIDTH / DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW-1:0] LP_BASE   = AW'(PROT_BASE);
  localparam logic [AW-1:0] LP_TOP    = AW'(PROT_TOP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DACC,
    S_DRSP,
    S_IFETCH,
    S_IRSP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]          r_mem [0:DEPTH-1];
  logic [AW-1:0]          r_d_addr;
  logic                   r_d_we;
  logic [DW-1:0]          r_d_wdata;
  logic [DW-1:0]          r_d_rdata;
  logic                   r_d_valid;
  logic [AW-1:0]          r_i_addr;
  logic [BW-1:0]          r_beat;
  logic [INSTR_WIDTH-1:0] r_i_rdata;
  logic                   r_i_valid;
  logic                   r_prot_err;

  logic [AW-1:0] w_fetch_addr;
  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_rd_byte;
  logic          w_in_win;
  logic          w_blocked;
  logic          w_mem_we;
  logic          w_perr_set;

  // Fetch addresses wrap naturally through the AW-bit adder.
  assign w_fetch_addr = r_i_addr + AW'(r_beat);
  assign w_rd_addr    = (r_state == S_IFETCH) ? w_fetch_addr : r_d_addr;
  assign w_rd_byte    = r_mem[w_rd_addr];

  assign w_in_win   = (r_d_addr >= LP_BASE) && (r_d_addr <= LP_TOP);
  assign w_blocked  = r_d_we && w_in_win && !prot_unlock;
  assign w_mem_we   = (r_state == S_DACC) && r_d_we && !w_blocked;
  assign w_perr_set = (r_state == S_DACC) && w_blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (d_req)      w_next = S_DACC;
        else if (i_req) w_next = S_IFETCH;
      end
      S_DACC:   w_next = S_DRSP;
      S_DRSP:   w_next = S_IDLE;
      S_IFETCH: if (r_beat == LAST_BEAT) w_next = S_IRSP;
      S_IRSP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_d_addr] <= r_d_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_addr   <= '0;
      r_d_we     <= 1'b0;
      r_d_wdata  <= '0;
      r_d_rdata  <= '0;
      r_d_valid  <= 1'b0;
      r_i_addr   <= '0;
      r_beat     <= '0;
      r_i_rdata  <= '0;
      r_i_valid  <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      r_d_valid  <= 1'b0;
      r_i_valid  <= 1'b0;
      // Set takes precedence over a coincident clear.
      r_prot_err <= w_perr_set || (r_prot_err && !prot_err_clr);
      case (r_state)
        S_IDLE: begin
          if (d_req) begin
            r_d_addr  <= d_addr;
            r_d_we    <= d_we;
            r_d_wdata <= d_wdata;
          end else if (i_req) begin
            r_i_addr <= i_addr;
            r_beat   <= '0;
          end
        end
        S_DACC: begin
          if (!r_d_we) r_d_rdata <= w_rd_byte;
        end
        S_DRSP: r_d_valid <= 1'b1;
        S_IFETCH: begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (r_beat == BW'(k)) r_i_rdata[k*DW +: DW] <= w_rd_byte;
          end
          r_beat <= r_beat + BW'(1);
        end
        S_IRSP:  r_i_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign i_rdata  = r_i_rdata;
  assign i_valid  = r_i_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;
  assign prot_err = r_prot_err;
  assign cpu_wait = rst_n && ((i_req && !r_i_valid) || (d_req && !r_d_valid));

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Self-checking bench for unified_mem_ctrl: transaction-level memory/latency model,
// per-cycle output comparison, plus literal pins from the directed scenarios.
module tb_unified_mem_ctrl;
  localparam int AW = 10, DW = 8, IW = 16, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [IW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          prot_unlock = 1'b0;
  logic          prot_err_clr = 1'b0;
  logic          prot_err;
  logic          cpu_wait;

  unified_mem_ctrl #(
    .MEMORY_DATA_WIDTH(DW),
    .MEMORY_ADDR_WIDTH(AW),
    .INSTR_WIDTH(IW),
    .PROT_BASE('h020),
    .PROT_TOP('h03F)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .prot_unlock(prot_unlock), .prot_err_clr(prot_err_clr),
    .prot_err(prot_err), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_last_drd = '0;
  logic          m_perr = 1'b0;
  int            exp_d_cyc = -1, exp_i_cyc = -1, exp_perr_cyc = -1, exp_clr_cyc = -1;
  logic [DW-1:0] exp_d_data = '0;
  logic [IW-1:0] exp_i_data = '0;
  logic [DW-1:0] cap_drd = '0;
  logic [IW-1:0] cap_ird = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_perr = 1'b0;
      chk("reset_outputs", {4'h0, i_valid, d_valid, prot_err, cpu_wait, i_rdata, d_rdata}, 32'h0);
    end else begin
      if (cyc == exp_clr_cyc) m_perr = 1'b0;
      if (cyc == exp_perr_cyc) m_perr = 1'b1;
      chk("d_valid", {31'b0, d_valid}, {31'b0, cyc == exp_d_cyc});
      chk("i_valid", {31'b0, i_valid}, {31'b0, cyc == exp_i_cyc});
      if (cyc == exp_d_cyc) begin
        chk("d_rdata", {24'b0, d_rdata}, {24'b0, exp_d_data});
        cap_drd = d_rdata;
      end
      if (cyc == exp_i_cyc) begin
        chk("i_rdata", {16'b0, i_rdata}, {16'b0, exp_i_data});
        cap_ird = i_rdata;
      end
      chk("cpu_wait", {31'b0, cpu_wait},
          {31'b0, (i_req && cyc != exp_i_cyc) || (d_req && cyc != exp_d_cyc)});
      chk("prot_err", {31'b0, prot_err}, {31'b0, m_perr});
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model of one data access, as seen by the requester: result and side effects.
  task automatic model_data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input bit unlock, input int n);
    bit blocked;
    blocked = we && (a >= 10'h020) && (a <= 10'h03F) && !unlock;
    if (!we) begin
      exp_d_data = m_mem[a];
      m_last_drd = m_mem[a];
    end else begin
      exp_d_data = m_last_drd;
      if (!blocked) m_mem[a] = wd;
    end
    if (blocked) exp_perr_cyc = n + 2;
    exp_d_cyc = n + 3;
  endtask

  function automatic logic [IW-1:0] model_fetch(input logic [AW-1:0] a);
    logic [IW-1:0] r;
    logic [AW-1:0] ak;
    r = '0;
    for (int k = 0; k < IW / DW; k++) begin
      ak = a + AW'(k);
      r[k*DW +: DW] = m_mem[ak];
    end
    return r;
  endfunction

  task automatic data_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit unlock, input bit clr_at_commit);
    int n;
    @(posedge clk); #1;
    n = cyc;
    prot_unlock = unlock;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    model_data(we, a, wd, unlock, n);
    if (clr_at_commit) begin
      wait_cyc(n + 1);
      prot_err_clr = 1'b1;
      exp_clr_cyc = n + 2;
      wait_cyc(n + 2);
      prot_err_clr = 1'b0;
    end
    wait_cyc(n + 3);
    @(negedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic fetch_op(input logic [AW-1:0] a);
    int n;
    @(posedge clk); #1;
    n = cyc;
    i_req = 1'b1; i_addr = a;
    exp_i_data = model_fetch(a);
    exp_i_cyc = n + 4;
    wait_cyc(n + 4);
    @(negedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic both_op(input bit we, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ia, input bit unlock);
    int n;
    @(posedge clk); #1;
    n = cyc;
    prot_unlock = unlock;
    d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd;
    i_req = 1'b1; i_addr = ia;
    model_data(we, da, wd, unlock, n);
    exp_i_data = model_fetch(ia);
    exp_i_cyc = n + 7;
    wait_cyc(n + 3);
    @(negedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    wait_cyc(n + 7);
    @(negedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic clr_op();
    @(posedge clk); #1;
    prot_err_clr = 1'b1;
    exp_clr_cyc = cyc + 1;
    @(posedge clk); #1;
    prot_err_clr = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'(10'h3F0 + $urandom_range(0, 15));
    return AW'($urandom_range(0, 126));
  endfunction

  initial begin
    int n;
    int r;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a < 128; a++) data_op(1'b1, AW'(a), DW'($urandom), 1'b1, 1'b0);
    for (int a = 10'h3F0; a < DEPTH; a++) data_op(1'b1, AW'(a), DW'($urandom), 1'b1, 1'b0);

    // Directed fetch
    data_op(1'b1, 10'h020, 8'h04, 1'b1, 1'b0);
    data_op(1'b1, 10'h021, 8'h5B, 1'b1, 1'b0);
    fetch_op(10'h020);
    chk("pin_fetch_5B04", {16'b0, cap_ird}, 32'h5B04);

    // Directed data write then read
    data_op(1'b1, 10'h004, 8'h0A, 1'b0, 1'b0);
    data_op(1'b0, 10'h004, 8'h00, 1'b0, 1'b0);
    chk("pin_read_0A", {24'b0, cap_drd}, 32'h0A);

    // Simultaneous requests: data wins, fetch follows after one idle cycle
    both_op(1'b0, 10'h004, 8'h00, 10'h020, 1'b0);
    chk("pin_arb_data", {24'b0, cap_drd}, 32'h0A);
    chk("pin_arb_fetch", {16'b0, cap_ird}, 32'h5B04);

    // Protection
    data_op(1'b0, 10'h025, 8'h00, 1'b0, 1'b0);
    data_op(1'b1, 10'h025, 8'hFF, 1'b0, 1'b0);
    chk("pin_perr_set", {31'b0, prot_err}, 32'h1);
    data_op(1'b0, 10'h025, 8'h00, 1'b0, 1'b0);
    clr_op();
    @(negedge clk); #1;
    chk("pin_perr_clr", {31'b0, prot_err}, 32'h0);
    data_op(1'b1, 10'h025, 8'hFF, 1'b1, 1'b0);
    data_op(1'b0, 10'h025, 8'h00, 1'b0, 1'b0);
    chk("pin_unlocked_FF", {24'b0, cap_drd}, 32'hFF);
    chk("pin_perr_stays0", {31'b0, prot_err}, 32'h0);

    // Set wins over a coincident clear
    data_op(1'b1, 10'h030, 8'h11, 1'b0, 1'b1);
    chk("pin_set_wins", {31'b0, prot_err}, 32'h1);
    clr_op();

    // Address wrap
    data_op(1'b1, 10'h3FF, 8'h34, 1'b0, 1'b0);
    data_op(1'b1, 10'h000, 8'h12, 1'b0, 1'b0);
    fetch_op(10'h3FF);
    chk("pin_wrap_1234", {16'b0, cap_ird}, 32'h1234);

    // Reset one cycle after fetch accept; request held into reset to exercise wait gating
    @(posedge clk); #1;
    n = cyc;
    i_req = 1'b1; i_addr = 10'h020;
    exp_i_cyc = n + 4;
    wait_cyc(n + 2);
    rst_n = 1'b0;
    exp_i_cyc = -1;
    m_last_drd = '0;
    repeat (2) @(posedge clk);
    #1 i_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    fetch_op(10'h020);
    chk("pin_refetch_5B04", {16'b0, cap_ird}, 32'h5B04);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: data_op(1'($urandom), rnd_addr(), DW'($urandom), 1'($urandom), 1'b0);
        4, 5:       fetch_op(rnd_addr());
        6:          both_op(1'($urandom), rnd_addr(), DW'($urandom), rnd_addr(), 1'($urandom));
        7:          clr_op();
        8:          data_op(1'b1, AW'(10'h020 + $urandom_range(0, 31)), DW'($urandom), 1'($urandom), 1'b0);
        default:    data_op(1'b1, AW'(10'h020 + $urandom_range(0, 31)), DW'($urandom), 1'b0, 1'b1);
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
Parametrised unified instruction/data memory controller for the serial CPU family. It owns a single byte-wide synchronous RAM array and exposes separate instruction-fetch and data ports. Multi-byte instructions are assembled little-endian from consecutive bytes. Simultaneous requests are arbitrated, and the CPU is stalled via cpu_wait. A protected address window guards instruction memory against accidental data writes.

Parameters:
MEMORY_DATA_WIDTH, 8, width of one RAM word (byte) and of the data port
MEMORY_ADDR_WIDTH, 10, byte address width; depth = 2**MEMORY_ADDR_WIDTH
INSTR_WIDTH, 16, instruction width; must be an integer multiple of MEMORY_DATA_WIDTH; BEATS = INSTR_WIDTH/MEMORY_DATA_WIDTH
PROT_BASE, 'h020, first protected byte address (inclusive)
PROT_TOP, 'h03F, last protected byte address (inclusive)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  instruction fetch request; level, held until i_valid
i_addr  input  MEMORY_ADDR_WIDTH  byte address of the instruction's low byte
i_rdata  output  INSTR_WIDTH  assembled instruction
i_valid  output  1  one-cycle pulse; i_rdata valid in this cycle
d_req  input  1  data access request; level, held until d_valid
d_we  input  1  1 = write, 0 = read; sampled with d_req
d_addr  input  MEMORY_ADDR_WIDTH  data byte address
d_wdata  input  MEMORY_DATA_WIDTH  write data
d_rdata  output  MEMORY_DATA_WIDTH  read data
d_valid  output  1  one-cycle pulse; access complete
prot_unlock  input  1  level; 1 permits writes inside [PROT_BASE, PROT_TOP]
prot_err_clr  input  1  synchronous clear of prot_err
prot_err  output  1  sticky flag: a blocked write occurred
cpu_wait  output  1  stall to CPU

Behaviour:
- Reset, async on rst_n low: FSM to IDLE; beat counter 0; i_rdata, d_rdata, i_valid, d_valid and prot_err all 0; cpu_wait forced to 0. RAM contents are not cleared.
- Reset mid-operation aborts the access. No valid pulse is produced. A write not yet committed is dropped.
- FSM states: IDLE, DACC, DRSP, IFETCH, IRSP.
- IDLE: d_req has priority.
  - If d_req is high: latch d_addr/d_we/d_wdata, go to DACC.
  - Else if i_req is high: latch i_addr, clear the beat counter, go to IFETCH.
- DACC: perform the RAM access, then go to DRSP.
  - A write commits on this edge unless blocked.
  - A read registers RAM[addr].
- DRSP: d_valid = 1 and d_rdata is driven (write cycles return the old/unchanged 0-value: d_rdata holds the last read). Next state is IDLE.
- Data latency: d_req sampled at edge E0, d_valid high in the cycle after edge E0+2.
- IFETCH: read byte RAM[(addr+k) mod depth] into i_rdata lane k (bits k*DW +: DW), for k = 0..BEATS-1, one beat per cycle. Go to IRSP after beat BEATS-1.
- IRSP: i_valid = 1. Next state is IDLE.
- Instruction latency: i_valid high after edge E0+1+BEATS (E0+3 for the defaults).
- An instruction fetch in progress is never pre-empted. A d_req arriving during it waits for IDLE.
- Back-to-back accesses: the requester may keep req high after valid. A new access is sampled at the next IDLE edge. One idle cycle separates transactions.
- Address wrap: fetch byte addresses wrap modulo 2**MEMORY_ADDR_WIDTH.
- Write protection: a write with d_addr inside [PROT_BASE, PROT_TOP] and prot_unlock = 0 at the DACC edge is blocked.
  - RAM is unchanged.
  - prot_err is set.
  - d_valid still pulses.
  - Reads are never blocked.
- prot_err clear vs set: prot_err_clr and a new blocked write on the same edge leave prot_err set (set wins).
- cpu_wait (combinational) = (i_req & ~i_valid) | (d_req & ~d_valid), gated to 0 during reset.
- i_rdata and d_rdata hold their values until overwritten by the next access of the same kind.

Test Plan:
- Fetch: preload RAM[0x20]=0x04, RAM[0x21]=0x?? (SET gr3 word 0x?? per encoding, e.g. 0x5B). i_req, i_addr=0x20 at E0 -> i_valid high only after E0+3, i_rdata=0x5B04, cpu_wait high E0..E0+2.
- Data: write d_addr=0x004, d_wdata=0x0A, then read 0x004 -> second transaction d_valid after E0+2 with d_rdata=0x0A; RAM[0x004]=0x0A.
- Arbitration: i_req and d_req both high in IDLE at E0 -> d_valid after E0+2, i_valid after E0+6 (one idle cycle, then 3). No stale pulses.
- Protection: write 0x25 <- 0xFF with prot_unlock=0 -> RAM[0x25] unchanged, prot_err=1, d_valid pulses. prot_err_clr -> 0. Repeat with prot_unlock=1 -> RAM[0x25]=0xFF, prot_err stays 0.
- Wrap: RAM[0x3FF]=0x34, RAM[0x000]=0x12, fetch i_addr=0x3FF -> i_rdata=0x1234.
- Reset mid-fetch: assert rst_n=0 one cycle after fetch accept -> i_valid never pulses, all outputs 0. After release, the same fetch returns the correct word with normal latency.
